// File: rtl/cordic_arbiter.sv
// Round-robin issue of NUM_CH channel angles into one shared pipelined CORDIC core, with tag return.
// Latency: handshake to rsp_valid_o is LATENCY+1 cycles; one issue per cycle.
// Backpressure: none. Ready is purely request/enable driven, and every response pulse must be consumed.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ch_en_i, req_valid_i          per-channel enable mask and request valid
//   req_angle_i                   packed per-channel angles, channel k at [k*WIDTH +: WIDTH]
//   req_ready_o                   one-hot grant (or zero)
//   cordic_angle_o                registered angle to the core
//   cordic_sine_i/cosine_i        core results
//   rsp_valid_o/ch_o/sine_o/cosine_o  registered response with owning channel
//   busy_o                        any issue still in flight
module cordic_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 16,
  parameter int LATENCY = 17,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [NUM_CH-1:0]       req_valid_i,
  input  logic [NUM_CH*WIDTH-1:0] req_angle_i,
  output logic [NUM_CH-1:0]       req_ready_o,
  output logic [WIDTH-1:0]        cordic_angle_o,
  input  logic [WIDTH-1:0]        cordic_sine_i,
  input  logic [WIDTH-1:0]        cordic_cosine_i,
  output logic                    rsp_valid_o,
  output logic [CH_W-1:0]         rsp_ch_o,
  output logic [WIDTH-1:0]        rsp_sine_o,
  output logic [WIDTH-1:0]        rsp_cosine_o,
  output logic                    busy_o
);

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]  angle_q;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant_oh;
  logic [CH_W-1:0]   grant_ch;
  logic              xfer;

  // Tag slot j holds the request issued j+1 edges ago; slot LATENCY lines up
  // with the core output on the edge the response is captured.
  logic [LATENCY:0]  tag_vld_q;
  logic [CH_W-1:0]   tag_ch_q [LATENCY+1];

  logic              rsp_valid_q;
  logic [CH_W-1:0]   rsp_ch_q;
  logic [WIDTH-1:0]  rsp_sine_q, rsp_cosine_q;

  // Round-robin search starting at ptr_q, wrapping at NUM_CH (not at 2**CH_W).
  always_comb begin
    int idx;
    idx      = 0;
    elig     = req_valid_i & ch_en_i;
    grant_oh = '0;
    grant_ch = '0;
    xfer     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!xfer && elig[idx]) begin
        xfer          = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_ch      = CH_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      angle_q      <= '0;
      tag_vld_q    <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_ch_q[i] <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_ch_q     <= '0;
      rsp_sine_q   <= '0;
      rsp_cosine_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      // Angle only moves on an issue, keeping the core input quiet when idle.
      if (xfer) angle_q <= req_angle_i[int'(grant_ch)*WIDTH +: WIDTH];
      tag_vld_q   <= {tag_vld_q[LATENCY-1:0], xfer};
      tag_ch_q[0] <= grant_ch;
      for (int i = 1; i <= LATENCY; i++) tag_ch_q[i] <= tag_ch_q[i-1];
      rsp_valid_q <= tag_vld_q[LATENCY];
      if (tag_vld_q[LATENCY]) begin
        rsp_ch_q     <= tag_ch_q[LATENCY];
        rsp_sine_q   <= cordic_sine_i;
        rsp_cosine_q <= cordic_cosine_i;
      end
    end
  end

  assign req_ready_o    = grant_oh;
  assign cordic_angle_o = angle_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_ch_o       = rsp_ch_q;
  assign rsp_sine_o     = rsp_sine_q;
  assign rsp_cosine_o   = rsp_cosine_q;
  assign busy_o         = (|tag_vld_q) | rsp_valid_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a delay-line core stub (sine = angle, cosine = ~angle).
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: none; every response pulse is observed as it occurs.
module tb_cordic_arbiter;
  localparam int NUM_CH  = 4;
  localparam int WIDTH   = 16;
  localparam int LATENCY = 17;
  localparam int CH_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       ch_en_i;
  logic [NUM_CH-1:0]       req_valid_i;
  logic [NUM_CH*WIDTH-1:0] req_angle_i;
  logic [NUM_CH-1:0]       req_ready_o;
  logic [WIDTH-1:0]        cordic_angle_o;
  logic [WIDTH-1:0]        cordic_sine_i;
  logic [WIDTH-1:0]        cordic_cosine_i;
  logic                    rsp_valid_o;
  logic [CH_W-1:0]         rsp_ch_o;
  logic [WIDTH-1:0]        rsp_sine_o;
  logic [WIDTH-1:0]        rsp_cosine_o;
  logic                    busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cordic_arbiter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ch_en_i        (ch_en_i),
    .req_valid_i    (req_valid_i),
    .req_angle_i    (req_angle_i),
    .req_ready_o    (req_ready_o),
    .cordic_angle_o (cordic_angle_o),
    .cordic_sine_i  (cordic_sine_i),
    .cordic_cosine_i(cordic_cosine_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ch_o       (rsp_ch_o),
    .rsp_sine_o     (rsp_sine_o),
    .rsp_cosine_o   (rsp_cosine_o),
    .busy_o         (busy_o)
  );

  // Core stub: LATENCY-deep delay line, no reset (its contents are don't-care after reset).
  logic [WIDTH-1:0] dl [LATENCY];
  always_ff @(posedge clk) begin
    dl[0] <= cordic_angle_o;
    for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
  end
  assign cordic_sine_i   = dl[LATENCY-1];
  assign cordic_cosine_i = ~dl[LATENCY-1];

  task automatic drain(input int n);
    req_valid_i = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ch_en_i = 4'hF; req_valid_i = '0; req_angle_i = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); end
    n_checks++; if (rsp_ch_o !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_ch got=%0d exp=0", rsp_ch_o); end
    n_checks++; if (rsp_sine_o !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_sine got=%h exp=0", rsp_sine_o); end
    n_checks++; if (rsp_cosine_o !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_cosine got=%h exp=0", rsp_cosine_o); end
    n_checks++; if (cordic_angle_o !== 16'h0) begin n_fail++; $display("FAIL reset_angle got=%h exp=0", cordic_angle_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int pulses = 0; int pulse_cyc = 0;
    logic [CH_W-1:0] g_ch = '0; logic [WIDTH-1:0] g_s = '0, g_c = '0;
    logic busy20 = 1'b1;
    req_angle_i[2*WIDTH +: WIDTH] = 16'h2000; req_valid_i = 4'b0100; #1;
    n_checks++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", req_ready_o); end
    @(negedge clk); req_valid_i = '0;
    n_checks++; if (cordic_angle_o !== 16'h2000) begin n_fail++; $display("FAIL single_angle got=%h exp=2000", cordic_angle_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy_o); end
    for (int c = 2; c <= 24; c++) begin
      @(negedge clk);
      if (rsp_valid_o === 1'b1) begin pulses++; pulse_cyc = c; g_ch = rsp_ch_o; g_s = rsp_sine_o; g_c = rsp_cosine_o; end
      if (c == 20) busy20 = busy_o;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
    n_checks++; if (pulse_cyc != 19) begin n_fail++; $display("FAIL single_latency got=%0d exp=19", pulse_cyc); end
    n_checks++; if (g_ch !== 2'd2) begin n_fail++; $display("FAIL single_ch got=%0d exp=2", g_ch); end
    n_checks++; if (g_s !== 16'h2000) begin n_fail++; $display("FAIL single_sine got=%h exp=2000", g_s); end
    n_checks++; if (g_c !== 16'hDFFF) begin n_fail++; $display("FAIL single_cosine got=%h exp=dfff", g_c); end
    n_checks++; if (busy20 !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall got=%b exp=0", busy20); end
  endtask

  task automatic test_fairness();
    req_valid_i = 4'b1000; #1;
    n_checks++; if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL fair_first got=%b exp=1000", req_ready_o); end
    @(negedge clk); req_valid_i = 4'b1001; #1;
    n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL fair_ch0 got=%b exp=0001", req_ready_o); end
    @(negedge clk); #1;
    n_checks++; if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL fair_ch3 got=%b exp=1000", req_ready_o); end
    @(negedge clk);
    drain(25);
  endtask

  task automatic test_contention();
    int got = 0; logic busy_low = 1'b0;
    logic [3:0] exp_rdy; logic [WIDTH-1:0] ea; logic [CH_W-1:0] ec;
    req_angle_i = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    req_valid_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1; exp_rdy = 4'b0001 << (i % 4);
      n_checks++; if (req_ready_o !== exp_rdy) begin n_fail++; $display("FAIL cont_grant%0d got=%b exp=%b", i, req_ready_o, exp_rdy); end
      @(negedge clk);
    end
    req_valid_i = '0;
    for (int c = 9; c <= 40; c++) begin
      @(negedge clk);
      if (got < 8 && busy_o !== 1'b1) busy_low = 1'b1;
      if (rsp_valid_o === 1'b1) begin
        ec = CH_W'(got % 4); ea = 16'((got % 4 + 1) << 12);
        n_checks++; if (rsp_ch_o !== ec) begin n_fail++; $display("FAIL cont_ch%0d got=%0d exp=%0d", got, rsp_ch_o, ec); end
        n_checks++; if (rsp_sine_o !== ea || rsp_cosine_o !== ~ea) begin n_fail++; $display("FAIL cont_data%0d got=%h/%h exp=%h/%h", got, rsp_sine_o, rsp_cosine_o, ea, ~ea); end
        n_checks++; if (c != 19 + got) begin n_fail++; $display("FAIL cont_timing%0d got=%0d exp=%0d", got, c, 19 + got); end
        got++;
      end
    end
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL cont_count got=%0d exp=8", got); end
    n_checks++; if (busy_low !== 1'b0) begin n_fail++; $display("FAIL cont_busy got=dropped exp=held"); end
  endtask

  task automatic test_enable();
    logic [3:0] exp_rdy; logic masked_seen = 1'b0;
    ch_en_i = 4'b1010; req_valid_i = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1; exp_rdy = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      if ((req_ready_o & 4'b0101) !== 4'b0000) masked_seen = 1'b1;
      n_checks++; if (req_ready_o !== exp_rdy) begin n_fail++; $display("FAIL en_grant%0d got=%b exp=%b", i, req_ready_o, exp_rdy); end
      @(negedge clk);
    end
    n_checks++; if (masked_seen !== 1'b0) begin n_fail++; $display("FAIL en_masked got=granted exp=never"); end
    ch_en_i = 4'hF;
    drain(25);
  endtask

  task automatic test_idle_hold();
    int pulses = 0; int pulse_cyc = 0;
    logic hold_bad = 1'b0, rsp_bad = 1'b0, busy19 = 1'b0, busy20 = 1'b1;
    req_angle_i[1*WIDTH +: WIDTH] = 16'h5A5A; req_valid_i = 4'b0010; #1;
    n_checks++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL idle_ready got=%b exp=0010", req_ready_o); end
    @(negedge clk); req_valid_i = '0;
    for (int c = 1; c <= 31; c++) begin
      if (c > 1) @(negedge clk);
      if (cordic_angle_o !== 16'h5A5A) hold_bad = 1'b1;
      if (rsp_valid_o === 1'b1) begin pulses++; pulse_cyc = c; end
      if (c >= 19 && (rsp_ch_o !== 2'd1 || rsp_sine_o !== 16'h5A5A || rsp_cosine_o !== 16'hA5A5)) rsp_bad = 1'b1;
      if (c == 19) busy19 = busy_o;
      if (c == 20) busy20 = busy_o;
    end
    n_checks++; if (hold_bad !== 1'b0) begin n_fail++; $display("FAIL idle_angle_hold got=changed exp=5a5a"); end
    n_checks++; if (pulses != 1 || pulse_cyc != 19) begin n_fail++; $display("FAIL idle_pulse got=%0d@%0d exp=1@19", pulses, pulse_cyc); end
    n_checks++; if (rsp_bad !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_hold got=changed exp=ch1 5a5a/a5a5"); end
    n_checks++; if (busy19 !== 1'b1 || busy20 !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b%b exp=10", busy19, busy20); end
  endtask

  task automatic test_reset_midflight();
    int pulses = 0; int pulse_cyc = 0;
    logic [WIDTH-1:0] g_s = '0;
    req_angle_i = {16'h0444, 16'h0333, 16'h0222, 16'h0111};
    req_valid_i = 4'hF;
    repeat (5) @(negedge clk);
    req_valid_i = '0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({rsp_valid_o, busy_o, rsp_ch_o, rsp_sine_o, rsp_cosine_o, cordic_angle_o, req_ready_o} !== '0) begin
        n_fail++;
        $display("FAIL rst_mid_outputs%0d got=v%b b%b ch%0d s%h c%h a%h r%b exp=all0", i, rsp_valid_o, busy_o, rsp_ch_o, rsp_sine_o, rsp_cosine_o, cordic_angle_o, req_ready_o);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rsp_valid_o === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_mid_discard got=%0d pulses exp=0", pulses); end
    req_angle_i[0 +: WIDTH] = 16'h0123; req_valid_i = 4'b0001; #1;
    n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=0001", req_ready_o); end
    @(negedge clk); req_valid_i = '0;
    pulses = 0;
    for (int c = 2; c <= 24; c++) begin
      @(negedge clk);
      if (rsp_valid_o === 1'b1) begin pulses++; pulse_cyc = c; g_s = rsp_sine_o; end
    end
    n_checks++; if (pulses != 1 || pulse_cyc != 19) begin n_fail++; $display("FAIL rst_mid_new_pulse got=%0d@%0d exp=1@19", pulses, pulse_cyc); end
    n_checks++; if (g_s !== 16'h0123) begin n_fail++; $display("FAIL rst_mid_new_sine got=%h exp=0123", g_s); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_contention();
    test_enable();
    test_idle_hold();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
